// File: rtl/mii_tx.sv
// MII transmit framer: prepends preamble/SFD, sends each byte low nibble first,
// aborts a starved frame with TX_ER and enforces the inter-frame gap.
//   state | meaning
//   IDLE  | line quiet, waiting for a pending byte
//   PRE   | preamble nibbles 0x5
//   SFD   | start-of-frame nibble 0xD, first byte accepted here
//   DATA  | payload; phase 0 low nibble, phase 1 high nibble and next accept
//   ERR   | two TX_ER clocks after a source underrun
//   DROP  | line quiet, discarding the rest of the aborted frame
//   IFG   | inter-frame gap
module mii_tx #(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24
) (
    input  logic       mii_clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       mii_en,
    output logic       mii_er,
    output logic [3:0] mii_d,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_ERR, S_DROP, S_IFG
    } state_t;

    localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_NIBBLES - 1);
    localparam logic [7:0] IFG_LOAD = 8'(IFG_NIBBLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_last_q, hold_last_d;
    logic       phase_q, phase_d;
    logic       en_q, en_d;
    logic       er_q, er_d;
    logic [3:0] d_q, d_d;
    logic       underrun_q, underrun_d;

    // Accept points come from state only, so in_valid never reaches in_ready.
    assign in_ready = (state_q == S_SFD) || (state_q == S_DROP) ||
                      (state_q == S_DATA && phase_q && !hold_last_q);

    assign mii_en   = en_q;
    assign mii_er   = er_q;
    assign mii_d    = d_q;
    assign underrun = underrun_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        phase_d     = phase_q;
        en_d        = en_q;
        er_d        = er_q;
        d_d         = d_q;
        underrun_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                en_d = 1'b0;
                d_d  = 4'h0;
                if (in_valid) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LOAD;
                    en_d    = 1'b1;
                    d_d     = 4'h5;
                end
            end
            S_PRE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_SFD;
                    d_d     = 4'hD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SFD, S_DATA: begin
                if (state_q == S_DATA && !phase_q) begin
                    phase_d = 1'b1;
                    d_d     = hold_q[7:4];
                end else if (state_q == S_DATA && hold_last_q) begin
                    state_d = S_IFG;
                    cnt_d   = IFG_LOAD;
                    en_d    = 1'b0;
                    d_d     = 4'h0;
                end else if (in_valid) begin
                    state_d     = S_DATA;
                    hold_d      = in_data;
                    hold_last_d = in_last;
                    phase_d     = 1'b0;
                    d_d         = in_data[3:0];
                end else begin
                    state_d    = S_ERR;
                    cnt_d      = 8'd1;
                    er_d       = 1'b1;
                    d_d        = 4'h0;
                    underrun_d = 1'b1;
                end
            end
            S_ERR: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DROP;
                    en_d    = 1'b0;
                    er_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DROP: begin
                if (in_valid && in_last) begin
                    state_d = S_IFG;
                    cnt_d   = IFG_LOAD;
                end
            end
            S_IFG: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (in_valid) begin
                    // Pending frame starts straight away so the gap is exact.
                    state_d = S_PRE;
                    cnt_d   = PRE_LOAD;
                    en_d    = 1'b1;
                    d_d     = 4'h5;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                er_d    = 1'b0;
                d_d     = 4'h0;
            end
        endcase
    end

    always_ff @(posedge mii_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            hold_q      <= 8'd0;
            hold_last_q <= 1'b0;
            phase_q     <= 1'b0;
            en_q        <= 1'b0;
            er_q        <= 1'b0;
            d_q         <= 4'h0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            phase_q     <= phase_d;
            en_q        <= en_d;
            er_q        <= er_d;
            d_q         <= d_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule
